// File: rtl/cpu_if_fetch_pkg.sv
// Shared 6502 CPU definitions: fetch FSM state type, opcode length decode and undocumented-opcode check.
package cpu_if_fetch_pkg;

  typedef enum logic [2:0] {
    S_OP,
    S_OPW,
    S_LO,
    S_HI,
    S_HOLD
  } if_state_t;

  // Ordered rules: BRK/RTI/RTS and JSR are the irregular cases, caught before the nibble patterns.
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
    else if (op == 8'h20) len = 2'd3;
    else if (op[3:0] == 4'h0 && op[4]) len = 2'd2;
    else if (op[3:0] == 4'h8 || op[3:0] == 4'hA) len = 2'd1;
    else if (op[3:0] == 4'hC || op[3:0] == 4'hD || op[3:0] == 4'hE) len = 2'd3;
    else if (op[3:0] == 4'h9 && op[4]) len = 2'd3;
    else len = 2'd2;
    return len;
  endfunction

  // Low nibble 3/7/B/F, or the x2 column except 82/A2/C2/E2.
  function automatic logic is_illegal_op(input logic [7:0] op);
    return (op[1:0] == 2'b11) || (op[3:0] == 4'h2 && (!op[7] || op[4]));
  endfunction

endpackage

// File: rtl/cpu_if_fetch_len_decode.sv
// Combinational opcode decoder: instruction length, plus undocumented-opcode flag with IF_ILLEGAL_TRAP_EN.
module if_len_decode
  import cpu_if_fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
`ifdef IF_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

`ifdef IF_ILLEGAL_TRAP_EN
  assign illegal = is_illegal_op(opcode);
  assign len     = illegal ? 2'd1 : decode_len(opcode);
`else
  assign len     = decode_len(opcode);
`endif

endmodule

// File: rtl/cpu_if_fetch.sv
// 6502 instruction fetch: byte-serial reads of opcode/operands, one bundle per valid/ready handshake to IE.
// IF_ILLEGAL_TRAP_EN adds if_illegal and parks the stage on undocumented opcodes until redirect/reset.
module cpu_if_fetch
  import cpu_if_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [7:0]  if_opcode,
  output logic [15:0] if_operand,
  output logic [1:0]  if_len,
  output logic [15:0] if_pc,
  input  logic        ie_redirect,
  input  logic [15:0] ie_redirect_pc
`ifdef IF_ILLEGAL_TRAP_EN
  ,
  output logic        if_illegal
`endif
);

  if_state_t   state;
  logic [15:0] pc;
  logic [7:0]  opcode_q;
  logic [15:0] operand_q;
  logic [1:0]  len_q;
  logic [15:0] if_pc_q;
  logic [1:0]  dec_len;
  logic        hold_release;

`ifdef IF_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q;

  if_len_decode u_len_decode (
    .opcode  (mem_rd_data),
    .len     (dec_len),
    .illegal (dec_illegal)
  );

  assign hold_release = if_ready && !illegal_q;
  assign if_illegal   = illegal_q && if_valid;
`else
  if_len_decode u_len_decode (
    .opcode (mem_rd_data),
    .len    (dec_len)
  );

  assign hold_release = if_ready;
`endif

  assign if_valid   = !rst && (state == S_HOLD);
  assign if_opcode  = opcode_q;
  assign if_operand = operand_q;
  assign if_len     = len_q;
  assign if_pc      = if_pc_q;

  // Next byte is requested in the same cycle the previous one is captured.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = pc;
    if (!rst) begin
      case (state)
        S_OP: begin
          mem_rd_en = 1'b1;
          mem_addr  = pc;
        end
        S_OPW: begin
          mem_rd_en = (dec_len != 2'd1);
          mem_addr  = pc + 16'd1;
        end
        S_LO: begin
          mem_rd_en = (len_q == 2'd3);
          mem_addr  = pc + 16'd2;
        end
        default: begin
          mem_rd_en = 1'b0;
          mem_addr  = pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      pc        <= RESET_PC;
      opcode_q  <= 8'h00;
      operand_q <= 16'h0000;
      len_q     <= 2'd0;
      if_pc_q   <= 16'h0000;
`ifdef IF_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (ie_redirect) begin
      // A redirect wins over pc+len even when the held bundle is accepted this cycle.
      state     <= S_OP;
      pc        <= ie_redirect_pc;
`ifdef IF_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_OP: state <= S_OPW;
        S_OPW: begin
          opcode_q  <= mem_rd_data;
          operand_q <= 16'h0000;
          len_q     <= dec_len;
          if_pc_q   <= pc;
`ifdef IF_ILLEGAL_TRAP_EN
          illegal_q <= dec_illegal;
`endif
          state     <= (dec_len == 2'd1) ? S_HOLD : S_LO;
        end
        S_LO: begin
          operand_q[7:0] <= mem_rd_data;
          state          <= (len_q == 2'd3) ? S_HI : S_HOLD;
        end
        S_HI: begin
          operand_q[15:8] <= mem_rd_data;
          state           <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_release) begin
            pc    <= pc + {14'd0, len_q};
            state <= S_OP;
          end
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
